// File: rtl/mult_share_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mult_share_pkg
// Description : Shared types and constants for the shared-multiplier arbiter.
//               Holds the FSM state encoding, the default requester count and
//               the operand / product widths of the shared multiplier.
// Revision    : 1.0 - initial release
// ============================================================================
package mult_share_pkg;

    localparam int DEF_NUM_REQ = 4;
    localparam int OPW         = 8;
    localparam int PRODW       = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage : mult_share_pkg
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick
// Description : Combinational round-robin picker. Searches the request vector
//               upward from ptr, wrapping modulo NUM_REQ, and returns the
//               first set requester.
// Ports       : req  - request vector
//               ptr  - starting position of the search
//               gnt  - one-hot grant (zero when no request)
//               idx  - index of the granted requester (0 when none)
//               any  - at least one request present
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [ID_W-1:0]    idx,
    output logic               any
);

    always_comb begin
        logic [ID_W-1:0] cand;
        gnt  = '0;
        idx  = '0;
        any  = 1'b0;
        cand = '0;
        // Walk offsets 0..NUM_REQ-1 from ptr; the first hit wins.
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = ID_W'((int'(ptr) + k) % NUM_REQ);
            if (!any && req[cand]) begin
                gnt[cand] = 1'b1;
                idx       = cand;
                any       = 1'b1;
            end
        end
    end

endmodule : rr_pick
`default_nettype wire

// File: rtl/mult_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mult_share_arbiter
// Description : Shares one 8x8 unsigned multiplier among NUM_REQ requesters
//               with round-robin arbitration and per-requester valid/ready
//               request and response handshakes.
// Ports       : clk, rst        - clock, synchronous active-high reset
//               req_valid/ready - per-requester request handshake
//               req_a, req_b    - packed 8-bit operands, requester i at [8i+:8]
//               resp_valid/ready- per-requester response handshake
//               resp_product    - 16-bit product for the flagged requester
//               grant_id        - requester currently being served
//               busy            - transaction in flight (state not IDLE)
// Revision    : 1.0 - initial release
// ============================================================================
module mult_share_arbiter
    import mult_share_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req_valid,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic [NUM_REQ*OPW-1:0] req_a,
    input  logic [NUM_REQ*OPW-1:0] req_b,
    output logic [NUM_REQ-1:0]     resp_valid,
    input  logic [NUM_REQ-1:0]     resp_ready,
    output logic [PRODW-1:0]       resp_product,
    output logic [ID_W-1:0]        grant_id,
    output logic                   busy
);

    state_t             state, state_next;
    logic [ID_W-1:0]    rr_ptr;
    logic [ID_W-1:0]    id_reg;
    logic [OPW-1:0]     a_reg, b_reg;
    logic [PRODW-1:0]   prod_reg;

    logic [NUM_REQ-1:0] pick_gnt;
    logic [ID_W-1:0]    pick_idx;
    logic               pick_any;
    logic [OPW-1:0]     a_sel, b_sel;
    logic [PRODW-1:0]   mul_out;
    logic               resp_hs;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr_pick (
        .req (req_valid),
        .ptr (rr_ptr),
        .gnt (pick_gnt),
        .idx (pick_idx),
        .any (pick_any)
    );

    // Operand mux steered by the one-hot grant.
    always_comb begin
        a_sel = '0;
        b_sel = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick_gnt[i]) begin
                a_sel = req_a[i*OPW +: OPW];
                b_sel = req_b[i*OPW +: OPW];
            end
        end
    end

    // The single shared 8x8 multiplier, fed only from the operand registers.
    assign mul_out = PRODW'(a_reg) * PRODW'(b_reg);

    assign resp_hs = (state == RESP) && resp_ready[id_reg];

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and handshake outputs
    always_comb begin
        state_next   = state;
        req_ready    = '0;
        resp_valid   = '0;
        resp_product = '0;
        grant_id     = id_reg;
        busy         = (state != IDLE);
        case (state)
            IDLE: begin
                req_ready = pick_gnt;
                grant_id  = pick_any ? pick_idx : rr_ptr;
                if (pick_any) begin
                    state_next = MUL;
                end
            end
            MUL: begin
                state_next = RESP;
            end
            RESP: begin
                resp_valid[id_reg] = 1'b1;
                resp_product       = prod_reg;
                if (resp_hs) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Datapath registers and round-robin pointer
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr   <= '0;
            id_reg   <= '0;
            a_reg    <= '0;
            b_reg    <= '0;
            prod_reg <= '0;
        end else begin
            if (state == IDLE && pick_any) begin
                a_reg  <= a_sel;
                b_reg  <= b_sel;
                id_reg <= pick_idx;
            end
            if (state == MUL) begin
                prod_reg <= mul_out;
            end
            // Pointer moves past the served requester only once its result
            // has been taken, which is what bounds every requester's wait.
            if (resp_hs) begin
                if (int'(id_reg) == NUM_REQ - 1) begin
                    rr_ptr <= '0;
                end else begin
                    rr_ptr <= id_reg + ID_W'(1);
                end
            end
        end
    end

endmodule : mult_share_arbiter
`default_nettype wire

// File: tb/tb_mult_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mult_share_arbiter
// Description : Directed self-checking bench for mult_share_arbiter with
//               hand-computed expected values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mult_share_arbiter;

    localparam int N = 4;

    logic          clk;
    logic          rst;
    logic [N-1:0]  req_valid;
    logic [N-1:0]  req_ready;
    logic [N*8-1:0] req_a;
    logic [N*8-1:0] req_b;
    logic [N-1:0]  resp_valid;
    logic [N-1:0]  resp_ready;
    logic [15:0]   resp_product;
    logic [1:0]    grant_id;
    logic          busy;

    int n_checks = 0;
    int n_fail   = 0;

    mult_share_arbiter #(.NUM_REQ(N)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_a        (req_a),
        .req_b        (req_b),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_product (resp_product),
        .grant_id     (grant_id),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs may be changed right after return.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ops(input int idx, input logic [7:0] a, input logic [7:0] b);
        req_a[idx*8 +: 8] = a;
        req_b[idx*8 +: 8] = b;
    endtask

    // One isolated transaction from a single requester, resp_ready high.
    task automatic run_single(input string tag, input int idx, input logic [7:0] a,
                              input logic [7:0] b, input logic [15:0] exp);
        logic [N-1:0] oh;
        oh = N'(1) << idx;
        set_ops(idx, a, b);
        req_valid = oh;
        #1;
        check({tag, "_ready"}, 32'(req_ready), 32'(oh));
        check({tag, "_gid"}, 32'(grant_id), 32'(idx));
        step();
        req_valid = '0;
        #1;
        check({tag, "_mul_busy"}, 32'(busy), 32'd1);
        check({tag, "_mul_rv"}, 32'(resp_valid), 32'd0);
        step();
        check({tag, "_rv"}, 32'(resp_valid), 32'(oh));
        check({tag, "_prod"}, 32'(resp_product), 32'(exp));
        check({tag, "_resp_busy"}, 32'(busy), 32'd1);
        step();
        check({tag, "_idle_busy"}, 32'(busy), 32'd0);
        check({tag, "_idle_rv"}, 32'(resp_valid), 32'd0);
    endtask

    initial begin
        rst        = 1'b1;
        req_valid  = '0;
        req_a      = '0;
        req_b      = '0;
        resp_ready = '1;

        // Reset state
        step();
        step();
        check("rst_ready", 32'(req_ready), 32'd0);
        check("rst_rv", 32'(resp_valid), 32'd0);
        check("rst_prod", 32'(resp_product), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_gid", 32'(grant_id), 32'd0);
        rst = 1'b0;
        step();

        // Single request and extremes (rr_ptr ends back at 0)
        run_single("single", 0, 8'd12, 8'd10, 16'd120);
        run_single("max", 1, 8'd255, 8'd255, 16'd65025);
        run_single("zero", 2, 8'd0, 8'd200, 16'd0);
        run_single("one", 3, 8'd1, 8'd173, 16'd173);

        // Round robin, all requesters valid continuously
        for (int i = 0; i < N; i++) set_ops(i, 8'(i + 1), 8'd3);
        req_valid = '1;
        for (int t = 0; t < 5; t++) begin
            int g;
            g = t % N;
            #1;
            check("rr_gid", 32'(grant_id), 32'(g));
            check("rr_ready", 32'(req_ready), 32'(1 << g));
            step();
            check("rr_mul_ready", 32'(req_ready), 32'd0);
            step();
            check("rr_rv", 32'(resp_valid), 32'(1 << g));
            check("rr_prod", 32'(resp_product), 32'(3 * (g + 1)));
            check("rr_resp_ready", 32'(req_ready), 32'd0);
            step();
        end
        req_valid = '0;
        #1;
        check("rr_end_busy", 32'(busy), 32'd0);

        // Backpressure on requester 2 (rr_ptr = 1)
        set_ops(2, 8'd7, 8'd9);
        req_valid = 4'b0100;
        #1;
        check("bp_ready", 32'(req_ready), 32'b0100);
        step();
        req_valid  = 4'b1011;
        resp_ready = 4'b1011;
        #1;
        check("bp_mul_ready", 32'(req_ready), 32'd0);
        for (int s = 0; s < 5; s++) begin
            step();
            check("bp_rv", 32'(resp_valid), 32'b0100);
            check("bp_prod", 32'(resp_product), 32'd63);
            check("bp_ready_stall", 32'(req_ready), 32'd0);
            check("bp_gid", 32'(grant_id), 32'd2);
        end
        req_valid  = '0;
        resp_ready = '1;
        #1;
        check("bp_hs_rv", 32'(resp_valid), 32'b0100);
        step();
        check("bp_done_busy", 32'(busy), 32'd0);
        check("bp_done_rv", 32'(resp_valid), 32'd0);

        // Pointer wrap (rr_ptr = 3): req3 wins, then req0
        set_ops(3, 8'd5, 8'd6);
        set_ops(0, 8'd2, 8'd50);
        req_valid = 4'b1001;
        #1;
        check("wrap_ready3", 32'(req_ready), 32'b1000);
        check("wrap_gid3", 32'(grant_id), 32'd3);
        step();
        step();
        check("wrap_rv3", 32'(resp_valid), 32'b1000);
        check("wrap_prod3", 32'(resp_product), 32'd30);
        step();
        check("wrap_ready0", 32'(req_ready), 32'b0001);
        check("wrap_gid0", 32'(grant_id), 32'd0);
        step();
        req_valid = '0;
        step();
        check("wrap_rv0", 32'(resp_valid), 32'b0001);
        check("wrap_prod0", 32'(resp_product), 32'd100);
        step();

        // Reset in RESP (rr_ptr = 1)
        set_ops(1, 8'd11, 8'd13);
        resp_ready = 4'b1101;
        req_valid  = 4'b0010;
        #1;
        check("mrst_ready", 32'(req_ready), 32'b0010);
        step();
        req_valid = '0;
        step();
        check("mrst_rv", 32'(resp_valid), 32'b0010);
        check("mrst_prod", 32'(resp_product), 32'd143);
        rst = 1'b1;
        step();
        check("mrst_rv_clr", 32'(resp_valid), 32'd0);
        check("mrst_prod_clr", 32'(resp_product), 32'd0);
        check("mrst_busy", 32'(busy), 32'd0);
        check("mrst_gid", 32'(grant_id), 32'd0);
        check("mrst_ready_clr", 32'(req_ready), 32'd0);
        rst        = 1'b0;
        resp_ready = '1;
        for (int s = 0; s < 3; s++) begin
            step();
            check("mrst_no_resp", 32'(resp_valid), 32'd0);
        end
        // rr_ptr back at 0: req0 beats req1
        set_ops(0, 8'd3, 8'd4);
        req_valid = 4'b0011;
        #1;
        check("mrst_ptr_ready", 32'(req_ready), 32'b0001);
        check("mrst_ptr_gid", 32'(grant_id), 32'd0);
        step();
        req_valid = '0;
        step();
        check("mrst_post_prod", 32'(resp_product), 32'd12);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_mult_share_arbiter
`default_nettype wire
